fft_mem_seq: RTL and testbench
==============================

Name: fft_mem_seq

Overview:
- Sequences an in-place radix-2 DIT FFT over the single-read, single-write block RAM holding the N complex samples.
- Samples are preloaded into the RAM in bit-reversed order.
- For each stage and each butterfly, the block:
  - reads operands A then B,
  - strobes the butterfly unit's operand capture,
  - supplies the twiddle index,
  - waits for the butterfly result,
  - writes the two results back to the same addresses.
- Sits between the top-level FFT control (start/done) and the RAM plus butterfly datapath.

Parameters:
N, 8, FFT length in points and RAM depth; power of two, N >= 4. Derived: AW = log2(N), TW = AW-1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_start  in  1  begin a transform; sampled only in IDLE
o_busy  in/out: out  1  high while a transform is in progress
o_done  out  1  one-cycle pulse when the transform has completed
o_rd_en  out  1  RAM read enable
o_rd_addr  out  AW  RAM read address
o_cap_a  out  1  butterfly captures RAM read data as operand A this cycle
o_cap_b  out  1  butterfly captures RAM read data as operand B this cycle
o_bf_start  out  1  one-cycle pulse: operands and twiddle are valid, butterfly may compute
o_tw_idx  out  TW  twiddle ROM index for the current butterfly
i_bf_done  in  1  butterfly results A' and B' are valid; honoured only in WAIT
o_wr_en  out  1  RAM write enable
o_wr_addr  out  AW  RAM write address
o_wr_sel  out  1  write-data mux select: 0 = A', 1 = B'
o_stage  out  AW  current stage index, 0..AW-1

Behaviour:
- Reset (rst high at a clk edge, from any state, including mid-transform):
  - state goes to IDLE; stage and k counters go to 0;
  - every output is 0.
  - No partial write completes after reset.
- RAM timing: read data is valid on the cycle after o_rd_en.
- Address generation, for stage s and butterfly k in 0..N/2-1:
  - half = 1<<s; pos = k & (half-1); grp = k >> s
  - addr_a = grp*2*half + pos; addr_b = addr_a + half
  - tw = pos << (AW-1-s)
  - All arithmetic is unsigned and truncated to AW/TW bits.
- o_tw_idx and o_stage are held stable from RD_A through WR_B of each butterfly.
- FSM states and transitions:
  - IDLE: outputs 0. i_start=1 -> RD_A, with stage=0, k=0.
  - RD_A: o_rd_en=1, o_rd_addr=addr_a, o_busy=1 -> RD_B.
  - RD_B: o_rd_en=1, o_rd_addr=addr_b, o_cap_a=1 -> CAP_B.
  - CAP_B: o_cap_b=1 -> START.
  - START: o_bf_start=1 -> WAIT.
  - WAIT: hold until i_bf_done=1 -> WR_A. A done seen in the first WAIT cycle advances immediately.
  - WR_A: o_wr_en=1, o_wr_addr=addr_a, o_wr_sel=0 -> WR_B.
  - WR_B: o_wr_en=1, o_wr_addr=addr_b, o_wr_sel=1. Then:
    - if k=N/2-1 and s=AW-1 -> DONE;
    - else if k=N/2-1: s++, k=0 -> RD_A;
    - else k++ -> RD_A.
  - DONE: o_done=1, o_busy=0 -> IDLE.
- o_busy is high in every state except IDLE and DONE.
- i_start while busy or in DONE is ignored; it is not queued.
- i_bf_done outside WAIT is ignored.
- Read and write never occur in the same cycle. There is no read-after-write hazard because butterflies are fully serialised.
- Cycle count:
  - With i_bf_done tied high, each butterfly takes 7 cycles.
  - Transform = (N/2)*AW*7 cycles plus 1 DONE cycle.
  - Each extra cycle i_bf_done is held low adds 1 cycle per butterfly.
- Counter wrap: k and s never exceed N/2-1 and AW-1; overflow is impossible by construction.

Test Plan:
1. N=8, i_bf_done tied 1, i_start pulse at cycle 0 -> o_busy high cycles 1..84, o_done pulse at cycle 85 only, o_busy=0 at 85, IDLE at 86.
2. N=8 address check, logging (wr_addr A, B, tw) per butterfly:
   - stage0: (0,1,0) (2,3,0) (4,5,0) (6,7,0)
   - stage1: (0,2,0) (1,3,2) (4,6,0) (5,7,2)
   - stage2: (0,4,0) (1,5,1) (2,6,2) (3,7,3)
   - Each read address pair must match its write pair.
3. Strobe ordering per butterfly -> rd_en(A), then rd_en(B)+cap_a, then cap_b, then bf_start, then >=1 WAIT cycle, then wr_en sel0, then wr_en sel1; never rd_en and wr_en together.
4. i_bf_done held low for 5 cycles after each bf_start -> transform takes 85 + 12*5 = 145 cycles; i_bf_done pulses in other states have no effect.
5. Assert rst during WAIT of stage1 k=2 -> next cycle all outputs 0, no o_wr_en. A subsequent i_start restarts at stage0 (0,1).
6. i_start held high throughout the transform -> a single o_done; a new transform begins at the cycle after DONE (IDLE sees i_start).

Source files
------------

// File: rtl/fft_mem_seq_if.sv
// Sequencer-side bundle: FFT control handshake, RAM read/write strobes and
// butterfly datapath strobes for fft_mem_seq.
interface fft_mem_seq_if #(
  parameter int N = 8
);
  localparam int AW = $clog2(N);
  localparam int TW = AW - 1;

  logic          i_start;
  logic          o_busy;
  logic          o_done;
  logic          o_rd_en;
  logic [AW-1:0] o_rd_addr;
  logic          o_cap_a;
  logic          o_cap_b;
  logic          o_bf_start;
  logic [TW-1:0] o_tw_idx;
  logic          i_bf_done;
  logic          o_wr_en;
  logic [AW-1:0] o_wr_addr;
  logic          o_wr_sel;
  logic [AW-1:0] o_stage;

  modport master (
    output i_start, i_bf_done,
    input  o_busy, o_done, o_rd_en, o_rd_addr, o_cap_a, o_cap_b, o_bf_start,
           o_tw_idx, o_wr_en, o_wr_addr, o_wr_sel, o_stage
  );

  modport slave (
    input  i_start, i_bf_done,
    output o_busy, o_done, o_rd_en, o_rd_addr, o_cap_a, o_cap_b, o_bf_start,
           o_tw_idx, o_wr_en, o_wr_addr, o_wr_sel, o_stage
  );
endinterface

// File: rtl/fft_mem_seq.sv
// In-place radix-2 DIT FFT sequencer: walks every stage/butterfly, reading A and B,
// strobing the butterfly, then writing A' and B' back to the same addresses.
module fft_mem_seq #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  fft_mem_seq_if.slave  bus
);
  localparam int AW = $clog2(N);
  localparam int TW = AW - 1;
  localparam int KW = AW - 1;
  localparam logic [AW-1:0] ONE_AW = AW'(1);
  localparam logic [AW-1:0] LAST_S = AW'(AW - 1);
  localparam logic [KW-1:0] LAST_K = KW'(N / 2 - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_A, S_RD_B, S_CAP_B, S_START, S_WAIT, S_WR_A, S_WR_B, S_DONE
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] stage_r, stage_s;
  logic [KW-1:0] k_r, k_s;

  logic          busy_s, done_s, rd_en_s, cap_a_s, cap_b_s, bf_start_s, wr_en_s, wr_sel_s;
  logic [AW-1:0] rd_addr_s, wr_addr_s, stage_out_s, addr_a_s, addr_b_s;
  logic [TW-1:0] tw_s;
  logic          busy_r, done_r, rd_en_r, cap_a_r, cap_b_r, bf_start_r, wr_en_r, wr_sel_r;
  logic [AW-1:0] rd_addr_r, wr_addr_r, stage_out_r;
  logic [TW-1:0] tw_r;

  function automatic logic [AW-1:0] addr_a_f(input logic [AW-1:0] s, input logic [KW-1:0] k);
    logic [AW-1:0] kk, half, pos, grp;
    kk   = {1'b0, k};
    half = ONE_AW << s;
    pos  = kk & (half - ONE_AW);
    grp  = kk >> s;
    return (grp << (s + ONE_AW)) + pos;
  endfunction

  function automatic logic [AW-1:0] addr_b_f(input logic [AW-1:0] s, input logic [KW-1:0] k);
    return addr_a_f(s, k) + (ONE_AW << s);
  endfunction

  function automatic logic [TW-1:0] tw_f(input logic [AW-1:0] s, input logic [KW-1:0] k);
    logic [AW-1:0] pos, t;
    pos = {1'b0, k} & ((ONE_AW << s) - ONE_AW);
    t   = pos << (LAST_S - s);
    return t[TW-1:0];
  endfunction

  // State and stage/butterfly counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      stage_r <= {AW{1'b0}};
      k_r     <= {KW{1'b0}};
    end else begin
      state_r <= state_s;
      stage_r <= stage_s;
      k_r     <= k_s;
    end
  end

  // Next-state and counter advance
  always_comb begin
    state_s = state_r;
    stage_s = stage_r;
    k_s     = k_r;
    case (state_r)
      S_IDLE: begin
        if (bus.i_start) begin
          state_s = S_RD_A;
          stage_s = {AW{1'b0}};
          k_s     = {KW{1'b0}};
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RD_A:  state_s = S_RD_B;
      S_RD_B:  state_s = S_CAP_B;
      S_CAP_B: state_s = S_START;
      S_START: state_s = S_WAIT;
      S_WAIT: begin
        if (bus.i_bf_done) begin
          state_s = S_WR_A;
        end else begin
          state_s = S_WAIT;
        end
      end
      S_WR_A: state_s = S_WR_B;
      S_WR_B: begin
        if (k_r == LAST_K) begin
          if (stage_r == LAST_S) begin
            state_s = S_DONE;
          end else begin
            state_s = S_RD_A;
            stage_s = stage_r + ONE_AW;
            k_s     = {KW{1'b0}};
          end
        end else begin
          state_s = S_RD_A;
          k_s     = k_r + KW'(1);
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    addr_a_s   = addr_a_f(stage_s, k_s);
    addr_b_s   = addr_b_f(stage_s, k_s);
    busy_s     = (state_s != S_IDLE) && (state_s != S_DONE);
    done_s     = 1'b0;
    rd_en_s    = 1'b0;
    rd_addr_s  = {AW{1'b0}};
    cap_a_s    = 1'b0;
    cap_b_s    = 1'b0;
    bf_start_s = 1'b0;
    wr_en_s    = 1'b0;
    wr_addr_s  = {AW{1'b0}};
    wr_sel_s   = 1'b0;
    if (busy_s) begin
      tw_s        = tw_f(stage_s, k_s);
      stage_out_s = stage_s;
    end else begin
      tw_s        = {TW{1'b0}};
      stage_out_s = {AW{1'b0}};
    end
    case (state_s)
      S_RD_A: begin
        rd_en_s   = 1'b1;
        rd_addr_s = addr_a_s;
      end
      S_RD_B: begin
        rd_en_s   = 1'b1;
        rd_addr_s = addr_b_s;
        cap_a_s   = 1'b1;
      end
      S_CAP_B: cap_b_s    = 1'b1;
      S_START: bf_start_s = 1'b1;
      S_WR_A: begin
        wr_en_s   = 1'b1;
        wr_addr_s = addr_a_s;
      end
      S_WR_B: begin
        wr_en_s   = 1'b1;
        wr_addr_s = addr_b_s;
        wr_sel_s  = 1'b1;
      end
      S_DONE:  done_s  = 1'b1;
      default: done_s  = 1'b0;
    endcase
  end

  // Output registers; reset clears everything so no write can straddle it
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_addr_r   <= {AW{1'b0}};
      cap_a_r     <= 1'b0;
      cap_b_r     <= 1'b0;
      bf_start_r  <= 1'b0;
      tw_r        <= {TW{1'b0}};
      wr_en_r     <= 1'b0;
      wr_addr_r   <= {AW{1'b0}};
      wr_sel_r    <= 1'b0;
      stage_out_r <= {AW{1'b0}};
    end else begin
      busy_r      <= busy_s;
      done_r      <= done_s;
      rd_en_r     <= rd_en_s;
      rd_addr_r   <= rd_addr_s;
      cap_a_r     <= cap_a_s;
      cap_b_r     <= cap_b_s;
      bf_start_r  <= bf_start_s;
      tw_r        <= tw_s;
      wr_en_r     <= wr_en_s;
      wr_addr_r   <= wr_addr_s;
      wr_sel_r    <= wr_sel_s;
      stage_out_r <= stage_out_s;
    end
  end

  assign bus.o_busy     = busy_r;
  assign bus.o_done     = done_r;
  assign bus.o_rd_en    = rd_en_r;
  assign bus.o_rd_addr  = rd_addr_r;
  assign bus.o_cap_a    = cap_a_r;
  assign bus.o_cap_b    = cap_b_r;
  assign bus.o_bf_start = bf_start_r;
  assign bus.o_tw_idx   = tw_r;
  assign bus.o_wr_en    = wr_en_r;
  assign bus.o_wr_addr  = wr_addr_r;
  assign bus.o_wr_sel   = wr_sel_r;
  assign bus.o_stage    = stage_out_r;
endmodule

// File: tb/tb_fft_mem_seq.sv
// Directed bench for fft_mem_seq at N=8: timing, address/twiddle sequence,
// strobe order, butterfly stalls, mid-transform reset and held start.
module tb_fft_mem_seq;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_mem_seq_if #(.N(N)) bus ();
  fft_mem_seq #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  logic [5:0]  strb;
  logic [18:0] outs;
  assign strb = {bus.o_rd_en, bus.o_cap_a, bus.o_cap_b, bus.o_bf_start, bus.o_wr_en, bus.o_wr_sel};
  assign outs = {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_rd_addr, bus.o_cap_a, bus.o_cap_b,
                 bus.o_bf_start, bus.o_tw_idx, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_sel, bus.o_stage};

  int exp_a  [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b  [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  // rd_en, cap_a, cap_b, bf_start, wr_en, wr_sel for RD_A..WR_B
  logic [5:0] pat [7] = '{6'b100000, 6'b110000, 6'b001000, 6'b000100,
                          6'b000000, 6'b000010, 6'b000011};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_bf_done = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_start = 1'b1;
    bus.i_bf_done = 1'b1;
    step();
    checks++;
    if (outs !== 19'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
    step();
    checks++;
    if (outs !== 19'd0) begin failures++; $display("FAIL reset_hold got=%h exp=0", outs); end
    rst = 1'b0;
    bus.i_start = 1'b0;
    step();
    checks++;
    if (outs !== 19'd0) begin failures++; $display("FAIL idle_after_reset got=%h exp=0", outs); end
  endtask

  task automatic test_cycle_count;
    do_reset();
    bus.i_bf_done = 1'b1;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int c = 1; c <= 84; c++) begin
      checks++;
      if (bus.o_busy !== 1'b1 || bus.o_done !== 1'b0) begin
        failures++;
        $display("FAIL busy_window cycle=%0d busy=%b done=%b exp busy=1 done=0", c, bus.o_busy, bus.o_done);
      end
      step();
    end
    checks++;
    if (bus.o_done !== 1'b1 || bus.o_busy !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle85 busy=%b done=%b exp busy=0 done=1", bus.o_busy, bus.o_done);
    end
    step();
    checks++;
    if (outs !== 19'd0) begin failures++; $display("FAIL idle_cycle86 got=%h exp=0", outs); end
  endtask

  task automatic test_addresses;
    logic [2:0] addr_obs, addr_exp;
    do_reset();
    bus.i_bf_done = 1'b1;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int b = 0; b < 12; b++) begin
      for (int p = 0; p < 7; p++) begin
        checks++;
        if (strb !== pat[p]) begin
          failures++;
          $display("FAIL strobes bf=%0d phase=%0d got=%b exp=%b", b, p, strb, pat[p]);
        end
        case (p)
          0: begin addr_obs = bus.o_rd_addr; addr_exp = 3'(exp_a[b]); end
          1: begin addr_obs = bus.o_rd_addr; addr_exp = 3'(exp_b[b]); end
          5: begin addr_obs = bus.o_wr_addr; addr_exp = 3'(exp_a[b]); end
          6: begin addr_obs = bus.o_wr_addr; addr_exp = 3'(exp_b[b]); end
          default: begin addr_obs = bus.o_rd_addr | bus.o_wr_addr; addr_exp = 3'd0; end
        endcase
        checks++;
        if (addr_obs !== addr_exp) begin
          failures++;
          $display("FAIL address bf=%0d phase=%0d got=%0d exp=%0d", b, p, addr_obs, addr_exp);
        end
        checks++;
        if (bus.o_tw_idx !== 2'(exp_tw[b]) || bus.o_stage !== 3'(b / 4)) begin
          failures++;
          $display("FAIL tw_stage bf=%0d phase=%0d got tw=%0d stage=%0d exp tw=%0d stage=%0d",
                   b, p, bus.o_tw_idx, bus.o_stage, exp_tw[b], b / 4);
        end
        step();
      end
    end
    checks++;
    if (bus.o_done !== 1'b1) begin failures++; $display("FAIL addr_run_done got=%b exp=1", bus.o_done); end
  endtask

  task automatic test_bf_done_delay;
    int cnt, cyc, done_cyc, nstart;
    do_reset();
    cnt = 99; cyc = 1; done_cyc = -1; nstart = 0;
    bus.i_bf_done = 1'b1;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    // done is low for the first five WAIT cycles, high everywhere else (ignored outside WAIT)
    while (cyc < 400 && done_cyc < 0) begin
      if (bus.o_done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        if (bus.o_bf_start === 1'b1) begin cnt = 0; nstart++; end
        else cnt++;
        bus.i_bf_done = !(cnt >= 1 && cnt <= 5);
        step();
        cyc++;
      end
    end
    checks++;
    if (done_cyc != 145) begin failures++; $display("FAIL stall_length got=%0d exp=145", done_cyc); end
    checks++;
    if (nstart != 12) begin failures++; $display("FAIL stall_bf_count got=%0d exp=12", nstart); end
  endtask

  task automatic test_reset_midway;
    int nstart;
    do_reset();
    nstart = 0;
    bus.i_bf_done = 1'b1;
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    for (int g = 0; g < 200; g++) begin
      if (bus.o_bf_start === 1'b1) nstart++;
      if (nstart == 7) break;
      step();
    end
    checks++;
    if (nstart != 7 || bus.o_stage !== 3'd1 || bus.o_tw_idx !== 2'd0) begin
      failures++;
      $display("FAIL reach_s1k2 starts=%0d stage=%0d tw=%0d exp starts=7 stage=1 tw=0",
               nstart, bus.o_stage, bus.o_tw_idx);
    end
    bus.i_bf_done = 1'b0;
    step();
    checks++;
    if (strb !== 6'b000000 || bus.o_busy !== 1'b1) begin
      failures++;
      $display("FAIL wait_state strobes=%b busy=%b exp strobes=000000 busy=1", strb, bus.o_busy);
    end
    rst = 1'b1;
    bus.i_bf_done = 1'b1;
    step();
    checks++;
    if (outs !== 19'd0) begin failures++; $display("FAIL midway_reset got=%h exp=0", outs); end
    step();
    checks++;
    if (bus.o_wr_en !== 1'b0 || outs !== 19'd0) begin
      failures++;
      $display("FAIL midway_reset_hold got=%h exp=0", outs);
    end
    rst = 1'b0;
    step();
    checks++;
    if (outs !== 19'd0) begin failures++; $display("FAIL idle_after_midway got=%h exp=0", outs); end
    bus.i_start = 1'b1;
    step();
    bus.i_start = 1'b0;
    checks++;
    if (bus.o_rd_en !== 1'b1 || bus.o_rd_addr !== 3'd0 || bus.o_stage !== 3'd0) begin
      failures++;
      $display("FAIL restart_rd_a rd_en=%b addr=%0d stage=%0d exp 1/0/0", bus.o_rd_en, bus.o_rd_addr, bus.o_stage);
    end
    step();
    checks++;
    if (bus.o_rd_addr !== 3'd1 || bus.o_cap_a !== 1'b1) begin
      failures++;
      $display("FAIL restart_rd_b addr=%0d cap_a=%b exp 1/1", bus.o_rd_addr, bus.o_cap_a);
    end
  endtask

  task automatic test_start_held;
    int ndone;
    logic done85, busy86;
    do_reset();
    ndone = 0; done85 = 1'b0; busy86 = 1'b1;
    bus.i_bf_done = 1'b1;
    bus.i_start = 1'b1;
    step();
    for (int c = 1; c <= 86; c++) begin
      if (bus.o_done === 1'b1) ndone++;
      if (c == 85) done85 = bus.o_done;
      if (c == 86) busy86 = bus.o_busy;
      step();
    end
    checks++;
    if (ndone != 1) begin failures++; $display("FAIL held_start_done_count got=%0d exp=1", ndone); end
    checks++;
    if (done85 !== 1'b1) begin failures++; $display("FAIL held_start_done85 got=%b exp=1", done85); end
    checks++;
    if (busy86 !== 1'b0) begin failures++; $display("FAIL held_start_idle86 got=%b exp=0", busy86); end
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_rd_en !== 1'b1 || bus.o_rd_addr !== 3'd0) begin
      failures++;
      $display("FAIL held_start_restart busy=%b rd_en=%b addr=%0d exp 1/1/0",
               bus.o_busy, bus.o_rd_en, bus.o_rd_addr);
    end
    bus.i_start = 1'b0;
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_bf_done = 1'b0;
    test_reset();
    test_cycle_count();
    test_addresses();
    test_bf_done_delay();
    test_reset_midway();
    test_start_held();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
